// File: rtl/sdram_line_buffer_pkg.sv
// Shared types and constants for the single-line SDRAM buffer.
package sdram_line_buffer_pkg;

    localparam int         LINE_HW        = 32;
    localparam logic [7:0] BURST_LEN_CODE = 8'd31;

    localparam int TAG_MSB = 31;
    localparam int TAG_LSB = 6;
    localparam int TAG_W   = TAG_MSB - TAG_LSB + 1;
    localparam int IDX_MSB = 5;
    localparam int IDX_LSB = 2;
    localparam int IDX_W   = IDX_MSB - IDX_LSB + 1;

    typedef enum logic [2:0] {
        IDLE,
        WB_REQ,
        WB_DATA,
        FILL_REQ,
        FILL_DATA,
        RESPOND
    } state_t;

    function automatic logic [31:0] line_base(input logic [TAG_W-1:0] line_tag);
        return {line_tag, {TAG_LSB{1'b0}}};
    endfunction

endpackage

// File: rtl/sdram_line_buffer_line_ram.sv
// Line storage: halfword array, one byte-masked word write port, two async halfword reads.
module line_ram
    import sdram_line_buffer_pkg::*;
#(
    parameter int DEPTH = LINE_HW,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [AW-2:0] wr_word,
    input  logic [3:0]    wr_be,
    input  logic [31:0]   wr_data,
    input  logic [AW-1:0] rd_addr_a,
    output logic [15:0]   rd_data_a,
    input  logic [AW-1:0] rd_addr_b,
    output logic [15:0]   rd_data_b
);

    logic [15:0] mem [DEPTH];

    // NOTE: the array has no reset; its contents only matter once a complete fill sets valid.
    always_ff @(posedge clk) begin
        if (wr_be[0]) mem[{wr_word, 1'b0}][7:0]  <= wr_data[7:0];
        if (wr_be[1]) mem[{wr_word, 1'b0}][15:8] <= wr_data[15:8];
        if (wr_be[2]) mem[{wr_word, 1'b1}][7:0]  <= wr_data[23:16];
        if (wr_be[3]) mem[{wr_word, 1'b1}][15:8] <= wr_data[31:24];
    end

    assign rd_data_a = mem[rd_addr_a];
    assign rd_data_b = mem[rd_addr_b];

endmodule

// File: rtl/sdram_line_buffer.sv
// One-line write-back buffer between a 32-bit CPU port and a 16-bit burst SDRAM controller.
module sdram_line_buffer #(
    parameter int         LINE_HW        = sdram_line_buffer_pkg::LINE_HW,
    parameter logic [7:0] BURST_LEN_CODE = sdram_line_buffer_pkg::BURST_LEN_CODE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_valid,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_be,
    output logic        cpu_ready,
    output logic [31:0] cpu_rdata,
    output logic        mem_rw_req,
    output logic        mem_rw,
    output logic [31:0] mem_address,
    output logic [15:0] mem_write_data,
    output logic [7:0]  mem_burst_len,
    input  logic [15:0] mem_read_data,
    input  logic        mem_data_bursting
);
    import sdram_line_buffer_pkg::*;

    localparam int               CNT_W     = $clog2(LINE_HW);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_HW - 1);

    state_t             state, state_next;
    logic [TAG_W-1:0]   tag;
    logic               valid, dirty, line_full;
    logic [CNT_W-1:0]   beat_cnt;
    logic [IDX_W-1:0]   word_idx;
    logic               hit, beat, enter_req, fill_we;
    logic [CNT_W-2:0]   wr_word;
    logic [3:0]         wr_be;
    logic [31:0]        wr_data;
    logic [CNT_W-1:0]   rd_addr_a;
    logic [15:0]        rd_data_a, rd_data_b;
    logic               unused_addr_lsbs;

    assign unused_addr_lsbs = ^cpu_addr[1:0];
    assign mem_burst_len    = BURST_LEN_CODE;

    assign word_idx  = cpu_addr[IDX_MSB:IDX_LSB];
    assign hit       = valid && (tag == cpu_addr[TAG_MSB:TAG_LSB]);
    assign beat      = mem_data_bursting && (state inside {WB_REQ, WB_DATA, FILL_REQ, FILL_DATA});
    assign enter_req = (state_next != state) && (state_next inside {WB_REQ, FILL_REQ});
    // Beats past the end of the line still arrive but must not overwrite the last halfword.
    assign fill_we   = beat && (state inside {FILL_REQ, FILL_DATA}) && !line_full;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every output and next-state signal gets a default first, so no path can infer a latch.
    always_comb begin
        state_next     = state;
        mem_rw_req     = 1'b0;
        mem_rw         = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        cpu_ready      = 1'b0;
        cpu_rdata      = '0;
        unique case (state)
            IDLE: begin
                if (cpu_valid) begin
                    if (hit)        state_next = RESPOND;
                    else if (dirty) state_next = WB_REQ;
                    else            state_next = FILL_REQ;
                end
            end
            WB_REQ, WB_DATA: begin
                mem_rw_req  = (state == WB_REQ);
                mem_rw      = 1'b1;
                mem_address = line_base(tag);
                if (mem_data_bursting) begin
                    mem_write_data = rd_data_a;
                    state_next     = WB_DATA;
                end else if (state == WB_DATA) begin
                    state_next = FILL_REQ;
                end
            end
            FILL_REQ, FILL_DATA: begin
                mem_rw_req  = (state == FILL_REQ);
                mem_address = line_base(cpu_addr[TAG_MSB:TAG_LSB]);
                if (mem_data_bursting)      state_next = FILL_DATA;
                else if (state == FILL_DATA) state_next = line_full ? RESPOND : FILL_REQ;
            end
            RESPOND: begin
                cpu_ready  = 1'b1;
                cpu_rdata  = cpu_we ? 32'h0 : {rd_data_b, rd_data_a};
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag       <= '0;
            valid     <= 1'b0;
            dirty     <= 1'b0;
            beat_cnt  <= '0;
            line_full <= 1'b0;
        end else begin
            if (enter_req) begin
                beat_cnt  <= '0;
                line_full <= 1'b0;
            end else if (beat) begin
                if (beat_cnt == LAST_BEAT) line_full <= 1'b1;
                else                       beat_cnt  <= beat_cnt + 1'b1;
            end
            if (enter_req && state_next == FILL_REQ) valid <= 1'b0;
            if (state == WB_DATA && !mem_data_bursting) dirty <= 1'b0;
            if (state == FILL_DATA && !mem_data_bursting && line_full) begin
                tag   <= cpu_addr[TAG_MSB:TAG_LSB];
                valid <= 1'b1;
            end
            if (state == RESPOND && cpu_we && cpu_be != 4'b0000) dirty <= 1'b1;
        end
    end

    always_comb begin
        wr_word = word_idx;
        wr_be   = 4'b0000;
        wr_data = cpu_wdata;
        if (fill_we) begin
            wr_word = beat_cnt[CNT_W-1:1];
            wr_be   = beat_cnt[0] ? 4'b1100 : 4'b0011;
            wr_data = {2{mem_read_data}};
        end else if (state == RESPOND && cpu_we) begin
            wr_be = cpu_be;
        end
    end

    assign rd_addr_a = (state == RESPOND) ? {word_idx, 1'b0} : beat_cnt;

    line_ram #(.DEPTH(LINE_HW)) u_line_ram (
        .clk       (clk),
        .wr_word   (wr_word),
        .wr_be     (wr_be),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_data_a (rd_data_a),
        .rd_addr_b ({word_idx, 1'b1}),
        .rd_data_b (rd_data_b)
    );

endmodule

// File: tb/tb_sdram_line_buffer.sv
// Directed self-checking bench for sdram_line_buffer with hand-computed expectations.
module tb_sdram_line_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_valid, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [3:0]  cpu_be;
    logic        cpu_ready;
    logic [31:0] cpu_rdata;
    logic        mem_rw_req, mem_rw;
    logic [31:0] mem_address;
    logic [15:0] mem_write_data;
    logic [7:0]  mem_burst_len;
    logic [15:0] mem_read_data;
    logic        mem_data_bursting;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] wb_cap [64];

    sdram_line_buffer dut (
        .clk               (clk),
        .reset             (reset),
        .cpu_valid         (cpu_valid),
        .cpu_we            (cpu_we),
        .cpu_addr          (cpu_addr),
        .cpu_wdata         (cpu_wdata),
        .cpu_be            (cpu_be),
        .cpu_ready         (cpu_ready),
        .cpu_rdata         (cpu_rdata),
        .mem_rw_req        (mem_rw_req),
        .mem_rw            (mem_rw),
        .mem_address       (mem_address),
        .mem_write_data    (mem_write_data),
        .mem_burst_len     (mem_burst_len),
        .mem_read_data     (mem_read_data),
        .mem_data_bursting (mem_data_bursting)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_drive(input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be);
        cpu_valid = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        cpu_be    = be;
    endtask

    task automatic cpu_idle();
        cpu_valid = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        cpu_be    = '0;
    endtask

    // Waits for a burst request, stalls one cycle, then plays n_beats beats.
    task automatic serve_burst(input string tag, input logic exp_rw, input logic [31:0] exp_addr,
                               input int n_beats, input logic [15:0] first);
        int   waited = 0;
        logic ready_seen = 1'b0;
        #2;
        while (!mem_rw_req && waited < 20) begin
            if (cpu_ready) ready_seen = 1'b1;
            tick();
            #2;
            waited++;
        end
        check({tag, "_req"}, mem_rw_req, 1'b1);
        check({tag, "_rw"}, mem_rw, exp_rw);
        check({tag, "_addr"}, mem_address, exp_addr);
        check({tag, "_no_early_ready"}, ready_seen, 1'b0);
        tick();
        #2;
        check({tag, "_req_held"}, mem_rw_req, 1'b1);
        for (int i = 0; i < n_beats; i++) begin
            tick();
            mem_data_bursting = 1'b1;
            mem_read_data     = first + 16'(i);
            #2;
            if (i < 64) wb_cap[i] = mem_write_data;
        end
        tick();
        mem_data_bursting = 1'b0;
        mem_read_data     = '0;
        #2;
        check({tag, "_req_drop"}, mem_rw_req, 1'b0);
    endtask

    task automatic wait_ready(input string tag, input logic [31:0] exp_rdata);
        int n = 0;
        do begin
            tick();
            #2;
            n++;
        end while (!cpu_ready && n < 20);
        check({tag, "_ready"}, cpu_ready, 1'b1);
        check({tag, "_rdata"}, cpu_rdata, exp_rdata);
        check({tag, "_req_vs_ready"}, mem_rw_req, 1'b0);
        tick();
        cpu_idle();
    endtask

    task automatic cpu_hit(input string tag, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be,
                           input logic [31:0] exp_rdata);
        tick();
        cpu_drive(we, addr, wdata, be);
        #2;
        check({tag, "_c1_ready"}, cpu_ready, 1'b0);
        check({tag, "_c1_req"}, mem_rw_req, 1'b0);
        tick();
        #2;
        check({tag, "_c2_ready"}, cpu_ready, 1'b1);
        check({tag, "_c2_rdata"}, cpu_rdata, exp_rdata);
        check({tag, "_c2_req"}, mem_rw_req, 1'b0);
        tick();
        cpu_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1);
    end

    initial begin
        int waited;
        reset             = 1'b1;
        mem_data_bursting = 1'b0;
        mem_read_data     = '0;
        cpu_idle();
        repeat (3) tick();
        #2;
        check("rst_ready", cpu_ready, 1'b0);
        check("rst_rdata", cpu_rdata, 32'h0);
        check("rst_req", mem_rw_req, 1'b0);
        check("rst_rw", mem_rw, 1'b0);
        check("rst_wdata", mem_write_data, 16'h0);
        check("burst_len", mem_burst_len, 8'd31);
        tick();
        reset = 1'b0;

        // Cold miss: fill line 0x0001_0040 with 0x0000..0x001F.
        tick();
        cpu_drive(1'b0, 32'h0001_0040, 32'h0, 4'h0);
        serve_burst("fill1", 1'b0, 32'h0001_0040, 32, 16'h0000);
        wait_ready("fill1", 32'h0001_0000);

        cpu_hit("hit_7c", 1'b0, 32'h0001_007C, 32'h0, 4'h0, 32'h001F_001E);
        cpu_hit("wr_44", 1'b1, 32'h0001_0044, 32'hDEAD_BEEF, 4'b0011, 32'h0);

        // Dirty miss: write-back of the old line, then fill of the new one.
        tick();
        cpu_drive(1'b0, 32'h0002_0000, 32'h0, 4'h0);
        serve_burst("wb1", 1'b1, 32'h0001_0040, 32, 16'h0000);
        check("wb1_beat0", wb_cap[0], 16'h0000);
        check("wb1_beat2", wb_cap[2], 16'hBEEF);
        check("wb1_beat3", wb_cap[3], 16'h0003);
        check("wb1_beat31", wb_cap[31], 16'h001F);
        serve_burst("fill2", 1'b0, 32'h0002_0000, 32, 16'h1000);
        wait_ready("fill2", 32'h1001_1000);

        // Zero byte-enable write changes nothing and leaves the line clean.
        cpu_hit("wr_be0", 1'b1, 32'h0002_0004, 32'hFFFF_FFFF, 4'b0000, 32'h0);
        cpu_hit("rd_04", 1'b0, 32'h0002_0004, 32'h0, 4'h0, 32'h1003_1002);

        // Clean miss with a short fill, retried; the retry overruns by two beats.
        tick();
        cpu_drive(1'b0, 32'h0003_0000, 32'h0, 4'h0);
        serve_burst("short", 1'b0, 32'h0003_0000, 20, 16'h2000);
        serve_burst("retry", 1'b0, 32'h0003_0000, 34, 16'h3000);
        wait_ready("retry", 32'h3001_3000);
        cpu_hit("rd_3c", 1'b0, 32'h0003_003C, 32'h0, 4'h0, 32'h301F_301E);

        // Reset during beat 10 of a write-back abandons it and drops the dirty data.
        cpu_hit("wr_3c", 1'b1, 32'h0003_003C, 32'h1234_5678, 4'b1111, 32'h0);
        tick();
        cpu_drive(1'b0, 32'h0004_0000, 32'h0, 4'h0);
        #2;
        waited = 0;
        while (!mem_rw_req && waited < 20) begin
            tick();
            #2;
            waited++;
        end
        check("rwb_req", mem_rw_req, 1'b1);
        check("rwb_rw", mem_rw, 1'b1);
        check("rwb_addr", mem_address, 32'h0003_0000);
        for (int i = 0; i < 10; i++) begin
            tick();
            mem_data_bursting = 1'b1;
            mem_read_data     = 16'h5000 + 16'(i);
            #2;
        end
        tick();
        reset = 1'b1;
        cpu_idle();
        #2;
        tick();
        reset = 1'b0;
        #2;
        check("rwb_post_ready", cpu_ready, 1'b0);
        check("rwb_post_rdata", cpu_rdata, 32'h0);
        check("rwb_post_req", mem_rw_req, 1'b0);
        check("rwb_post_rw", mem_rw, 1'b0);
        check("rwb_post_wdata", mem_write_data, 16'h0);
        tick();
        #2;
        check("rwb_ignored_wdata", mem_write_data, 16'h0);
        check("rwb_ignored_req", mem_rw_req, 1'b0);
        tick();
        mem_data_bursting = 1'b0;
        tick();
        cpu_drive(1'b0, 32'h0004_0000, 32'h0, 4'h0);
        serve_burst("rfill", 1'b0, 32'h0004_0000, 32, 16'h4000);
        wait_ready("rfill", 32'h4001_4000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sdram_line_buffer.md
SDRAM_LINE_BUFFER -- requirements
Module: sdram_line_buffer

Interface
REQ-001 Parameter LINE_HW, default 32, SHALL set halfwords per line (line = 64 bytes), equal to the controller's fixed burst length.
REQ-002 Parameter BURST_LEN_CODE, default 8'd31, SHALL be the value driven on mem_burst_len.
REQ-003 Ports: clk  in  1  the only clock; all logic rising-edge.
REQ-004 Ports: reset  in  1  synchronous, active-high.
REQ-005 Ports: cpu_valid  in  1  CPU request; cpu_we  in  1  1=write; cpu_addr  in  32  byte address, word aligned; cpu_wdata  in  32  write data; cpu_be  in  4  byte enables.
REQ-006 Ports: cpu_ready  out  1  one-cycle completion pulse; cpu_rdata  out  32  read data, valid when cpu_ready=1.
REQ-007 Ports: mem_rw_req  out  1  burst request; mem_rw  out  1  1=write burst; mem_address  out  32  line base address (bits 5:0 zero); mem_write_data  out  16  beat data; mem_burst_len  out  8.
REQ-008 Ports: mem_read_data  in  16  beat data; mem_data_bursting  in  1  high on every beat cycle of an active burst.

Function
REQ-009 Block SHALL hold one line: 32x16 data array, 26-bit tag (addr[31:6]), valid bit, dirty bit.
REQ-010 Hit = valid and tag==cpu_addr[31:6]; word index = cpu_addr[5:2], halfwords 2i (low) and 2i+1 (high).
REQ-011 FSM states SHALL be IDLE, WB_REQ, WB_DATA, FILL_REQ, FILL_DATA, RESPOND.
REQ-012 IDLE, cpu_valid, hit -> RESPOND; next cycle cpu_ready=1 (hit latency 2 cycles from valid to ready inclusive).
REQ-013 IDLE, cpu_valid, miss, dirty -> WB_REQ; miss, clean -> FILL_REQ.
REQ-014 *_REQ: mem_rw_req=1, mem_address=line base (old tag for WB, cpu_addr[31:6] for FILL), mem_rw=1 WB / 0 FILL; held until first cycle mem_data_bursting=1, then dropped and state -> *_DATA.
REQ-015 Beat counter (5 bits) SHALL clear on entry to *_REQ and increment on every cycle mem_data_bursting=1; saturates at LINE_HW-1; beats beyond LINE_HW ignored.
REQ-016 WB: mem_write_data = array[beat counter] combinationally during bursting cycles.
REQ-017 FILL: array[beat counter] <= mem_read_data on every bursting cycle.
REQ-018 *_DATA ends on first cycle mem_data_bursting=0; WB -> dirty<=0, FILL_REQ; FILL with exactly LINE_HW beats -> tag<=new, valid<=1, RESPOND.
REQ-019 Short fill (<LINE_HW beats) SHALL leave valid=0 and return to FILL_REQ (retry).
REQ-020 RESPOND: read -> cpu_rdata={array[2i+1],array[2i]}; write -> bytes with cpu_be set merged, dirty<=1, cpu_rdata=0; cpu_ready=1 one cycle; -> IDLE.
REQ-021 cpu_be=4'b0000 write SHALL complete normally without modifying data or setting dirty.
REQ-022 CPU inputs SHALL be held stable from cpu_valid until cpu_ready; block need not latch them.
REQ-023 mem_burst_len SHALL constantly equal BURST_LEN_CODE.
REQ-024 cpu_ready SHALL never assert in the same cycle as mem_rw_req.

Reset
REQ-025 Reset SHALL force IDLE, valid=0, dirty=0, tag=0, counter=0, cpu_ready=0, cpu_rdata=0, mem_rw_req=0, mem_rw=0, mem_write_data=0; array contents unspecified.
REQ-026 Reset mid-burst SHALL abandon the transfer immediately; subsequent mem_data_bursting cycles ignored until next *_REQ; dirty data lost.

Structure
REQ-027 Shared package SHALL hold the state enumeration, LINE_HW, BURST_LEN_CODE and tag/index bit-range constants.
REQ-028 The data array SHALL be one sub-module, line_ram (32x16, one sync write port, two async read ports).

Verification
REQ-029 Read 0x0001_0040 after reset -> one FILL request, mem_address=0x0001_0040, mem_rw=0; 32 beats 0x0000..0x001F -> cpu_rdata=0x0001_0000.
REQ-030 Then read 0x0001_007C -> hit, no mem_rw_req, cpu_ready 2 cycles after valid, cpu_rdata=0x001F_001E.
REQ-031 Write 0xDEADBEEF be=4'b0011 to 0x0001_0044, then read 0x0002_0000 -> WB at 0x0001_0040, beat 2 = 0xBEEF, beat 3 = 0x0003, then FILL at 0x0002_0000.
REQ-032 Fill where mem_data_bursting lasts 20 cycles -> no cpu_ready, second FILL request to same address issued.
REQ-033 Assert reset during beat 10 of a WB -> outputs at reset values next cycle; following read miss issues FILL only (no WB).
REQ-034 Fill with 34 bursting cycles -> beats 32-33 ignored, line valid, data of index 31 = beat 31 value.
